// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : game_pkg
//  Purpose  : Shared definitions for the rhythm-game score path: game-state
//             encodings (shared with the score counter), lane count, combo
//             width/limit and a saturating adder used for combo and miss
//             statistics.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SONG_SELECT = 2'd1,
        GAME_PLAY   = 2'd2,
        GAME_OVER   = 2'd3
    } game_state_e;

    localparam int                 LANES     = 2;
    localparam int                 COMBO_W   = 8;
    localparam logic [COMBO_W-1:0] COMBO_MAX = 8'd255;

    // COMBO_MAX is all ones, so the carry bit alone flags overflow.
    function automatic logic [COMBO_W-1:0] sat_add(input logic [COMBO_W-1:0] a,
                                                   input logic [1:0]         b);
        logic [COMBO_W:0] s;
        s = {1'b0, a} + {{(COMBO_W-1){1'b0}}, b};
        return s[COMBO_W] ? COMBO_MAX : s[COMBO_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/judge_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : judge_ctrl_if
//  Purpose   : Control/result bundle between the game front end and
//              judge_ctrl.
//  Signals   : start_btn, sel_btn, song_end, tick  - one-cycle pulses
//              note[LANES], hit_btn[LANES]         - lane inputs
//              current_state, inp, combo,
//              max_combo, miss_cnt                  - judge results
//  Modports  : master (drives pulses/buttons), slave (judge_ctrl)
//  Revision  : 1.0  initial release
// ============================================================================
interface judge_ctrl_if;
    import game_pkg::*;

    logic               start_btn;
    logic               sel_btn;
    logic               song_end;
    logic               tick;
    logic [LANES-1:0]   note;
    logic [LANES-1:0]   hit_btn;
    logic [1:0]         current_state;
    logic [LANES-1:0]   inp;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [COMBO_W-1:0] miss_cnt;

    modport master (
        output start_btn, sel_btn, song_end, tick, note, hit_btn,
        input  current_state, inp, combo, max_combo, miss_cnt
    );

    modport slave (
        input  start_btn, sel_btn, song_end, tick, note, hit_btn,
        output current_state, inp, combo, max_combo, miss_cnt
    );

endinterface
`default_nettype wire

// File: rtl/lane_judge.sv
`default_nettype none
// ============================================================================
//  Module   : lane_judge
//  Purpose  : One button lane: rising-edge detect, hit window down-counter
//             and per-cycle hit/miss verdicts.
//  Ports    : clk, rst      - clock, async active-high reset
//             play_i        - judging enabled (GAME_PLAY, not song-end cycle);
//                             when low the window is discarded silently
//             tick_i,note_i - chart strobe and this lane's note flag
//             hit_btn_i     - lane button level
//             hit_o, miss_o - verdicts for this cycle
//  Config   : JUDGE_GHOST_PENALTY_EN - a press on a closed window is a miss
//  Revision : 1.0  initial release
// ============================================================================
module lane_judge #(
    parameter int WINDOW = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic play_i,
    input  wire logic tick_i,
    input  wire logic note_i,
    input  wire logic hit_btn_i,
    output logic      hit_o,
    output logic      miss_o
);

    logic       prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       rise;
    logic       win_open;
    logic       load;

    always_comb begin
        rise     = hit_btn_i & ~prev_q;
        win_open = (cnt_q != 8'd0);
        load     = tick_i & note_i;
        hit_o    = 1'b0;
        miss_o   = 1'b0;
        cnt_d    = 8'd0;
        if (play_i) begin
            // The press is judged against the window already open; a note
            // arriving in the same cycle only loads afterwards.
            hit_o  = rise & win_open;
            // Expiry and supersede in one cycle are the same old note: one miss.
            miss_o = win_open & ~rise & ((cnt_q == 8'd1) | load);
`ifdef JUDGE_GHOST_PENALTY_EN
            if (rise && !win_open) begin
                miss_o = 1'b1;
            end
`endif
            if (load) begin
                cnt_d = 8'(WINDOW);
            end else if (win_open && !rise) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            prev_q <= hit_btn_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/judge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : judge_ctrl
//  Purpose  : Rhythm-game gameplay sequencer. Game-state FSM, per-lane note
//             judging, combo and results-screen statistics.
//  Ports    : clk, rst  - clock, async active-high reset
//             bus       - judge_ctrl_if.slave (pulses, lane inputs, results)
//  Params   : WINDOW    - cycles a note stays hittable after its tick (1..255)
//  Config   : JUDGE_GHOST_PENALTY_EN - presses on closed lanes count as misses
//  Revision : 1.0  initial release
// ============================================================================
module judge_ctrl
    import game_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    judge_ctrl_if.slave bus
);

    game_state_e        state_q, state_d;
    logic [LANES-1:0]   inp_q, inp_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_q, max_d;
    logic [COMBO_W-1:0] miss_q, miss_d;
    logic [LANES-1:0]   hit_w;
    logic [LANES-1:0]   miss_w;
    logic [1:0]         n_hit;
    logic [1:0]         n_miss;
    logic               play;

    // The song_end cycle drops every verdict and discards open windows.
    assign play = (state_q == GAME_PLAY) && !bus.song_end;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            lane_judge #(.WINDOW(WINDOW)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .play_i    (play),
                .tick_i    (bus.tick),
                .note_i    (bus.note[i]),
                .hit_btn_i (bus.hit_btn[i]),
                .hit_o     (hit_w[i]),
                .miss_o    (miss_w[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        inp_d   = '0;
        combo_d = combo_q;
        max_d   = max_q;
        miss_d  = miss_q;
        n_hit   = 2'd0;
        n_miss  = 2'd0;
        for (int i = 0; i < LANES; i++) begin
            n_hit  += {1'b0, hit_w[i]};
            n_miss += {1'b0, miss_w[i]};
        end
        case (state_q)
            IDLE: begin
                if (bus.start_btn) state_d = SONG_SELECT;
            end
            SONG_SELECT: begin
                if (bus.sel_btn) begin
                    state_d = GAME_PLAY;
                    combo_d = '0;
                    max_d   = '0;
                    miss_d  = '0;
                end
            end
            GAME_PLAY: begin
                if (bus.song_end) begin
                    state_d = GAME_OVER;
                end else begin
                    inp_d   = hit_w;
                    // A miss breaks the streak even if the other lane hit.
                    combo_d = (n_miss != 2'd0) ? '0 : sat_add(combo_q, n_hit);
                    if (combo_d > max_q) max_d = combo_d;
                    miss_d  = sat_add(miss_q, n_miss);
                end
            end
            GAME_OVER: begin
                if (bus.start_btn) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            inp_q   <= '0;
            combo_q <= '0;
            max_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.current_state = state_q;
    assign bus.inp           = inp_q;
    assign bus.combo         = combo_q;
    assign bus.max_combo     = max_q;
    assign bus.miss_cnt      = miss_q;

endmodule
`default_nettype wire
